pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised fetch-stage program counter for the pipelined CPU; holds curPC and selects its next value.
//  Adds to the base PC register: programmable jump-register wait (JR_WAIT), aligned mispredict redirect,
//  explicit state machine, fetch-valid qualifier and a saturating redirect counter.
//  Sits at the head of Fetch: drives IM address; consumes nextPC from NPC logic, newPC from Execute.
// PARAMETERS
//  WIDTH      32            address width, bits
//  RESET_PC   32'h0000_3000 curPC value after reset; must be INSN_BYTES-aligned
//  INSN_BYTES 4             instruction size, power of 2 (>=2); log2 = AL
//  JR_WAIT    2             edges curPC is held after JumpReg before loading nextPC, 1..15
//  CNT_W      16            width of redirect counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-low reset
//  stall        in   1      hazard stall: hold curPC and all state
//  fail         in   1      branch mispredict / redirect request from Execute
//  JumpReg      in   1      jump-register in flight; level, held by decode until target resolved
//  nextPC       in   WIDTH  sequential/branch target from NPC logic
//  newPC        in   WIDTH  address of mispredicted instruction
//  curPC        out  WIDTH  current fetch address (registered)
//  pc_valid     out  1      1 = curPC holds a fetchable instruction this cycle
//  jr_busy      out  1      1 = state JRWAIT
//  redirect_cnt out  CNT_W  number of accepted fail redirects, saturating
// BEHAVIOUR
//  Reset (reset==0 at edge): curPC=RESET_PC, state=RUN, cnt=0, redirect_cnt=0; pc_valid=1, jr_busy=0.
//  States: RUN, JRWAIT. Internal cnt, 4 bits. All outputs registered or decoded from state only.
//  Priority per edge: reset > fail > stall > state action.
//  fail==1: curPC <= {newPC[WIDTH-1:AL],AL'b0} + INSN_BYTES (low bits of newPC dropped, wraps mod 2^WIDTH);
//    state<=RUN, cnt<=0; redirect_cnt++ unless all ones. Overrides stall and JRWAIT.
//  stall==1 (no fail): curPC, state, cnt unchanged. Counter frozen in JRWAIT.
//  RUN, JumpReg==0: curPC <= nextPC.
//  RUN, JumpReg==1: curPC held, cnt<=1, state<=JRWAIT.
//  JRWAIT, JumpReg==1, cnt<JR_WAIT: curPC held, cnt++.
//  JRWAIT, JumpReg==1, cnt==JR_WAIT: curPC <= nextPC, cnt<=0, state<=RUN.
//    => with no stalls, nextPC loaded on (JR_WAIT+1)-th edge counted from first JumpReg edge.
//  JRWAIT, JumpReg==0 (aborted by upstream): state<=RUN, cnt<=0, curPC <= nextPC (normal cycle).
//  pc_valid = (state==RUN); jr_busy = (state==JRWAIT). Held PC during JRWAIT is not fetched.
//  nextPC is not realigned; misaligned nextPC passes through unchanged.
//  Reset mid-JRWAIT or with fail asserted: reset wins, all state to reset values.
//  X/Z on stall or JumpReg are not tolerated; bench drives known values always.
// TESTING
//  1 Reset: reset=0 one edge, then 1 -> curPC=0x3000, pc_valid=1, jr_busy=0, redirect_cnt=0.
//  2 Sequential: nextPC=curPC+4 each cycle, 3 edges -> curPC 0x3004,0x3008,0x300C; stall=1 2 edges -> holds 0x300C.
//  3 JR, JR_WAIT=2: JumpReg=1 held, nextPC=0x3400 -> curPC held 2 edges, jr_busy=1, pc_valid=0;
//    3rd edge curPC=0x3400, jr_busy=0; stall=1 mid-wait adds exactly one hold edge.
//  4 Redirect: fail=1, newPC=0x3011 -> curPC=0x3014, redirect_cnt=1; fail with stall=1 and JRWAIT -> same, state RUN.
//  5 Reset mid-JRWAIT: cnt=1, reset=0 -> curPC=0x3000, jr_busy=0, next JumpReg restarts full wait.
//  6 Saturation, CNT_W=2: 5 fail edges -> redirect_cnt=3; newPC=0xFFFF_FFFC -> curPC wraps to 0x0000_0000.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter.
// Holds curPC and picks its next value from three sources, highest priority first:
// the mispredict redirect, the stall hold, and the normal nextPC / jump-register flow.
// A jump-register keeps the PC parked in JRWAIT for JR_WAIT edges before nextPC is taken.
//
// Handshake: there is no valid/ready pair here. stall is a hold request that freezes all
// state. fail is a one-edge redirect command that is taken on the edge it is high.
// pc_valid qualifies curPC for the instruction memory: the PC held during JRWAIT is not fetched.
module pc_unit #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_PC   = 32'h0000_3000,
    parameter int                 INSN_BYTES = 4,
    parameter int                 JR_WAIT    = 2,
    parameter int                 CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fail,
    input  logic             JumpReg,
    input  logic [WIDTH-1:0] nextPC,
    input  logic [WIDTH-1:0] newPC,
    output logic [WIDTH-1:0] curPC,
    output logic             pc_valid,
    output logic             jr_busy,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_JRWAIT = 1'b1
    } pc_state_e;

    // Clearing the low address bits aligns newPC to an instruction boundary.
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSN_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INSN_BYTES - 1));
    localparam logic [3:0]       JR_WAIT_C  = 4'(JR_WAIT);

    pc_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    // State register: synchronous active-low reset, otherwise load the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            pc_q    <= RESET_PC;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rcnt_q  <= rcnt_d;
        end
    end

    // Next-state logic: redirect beats stall, stall beats the normal RUN/JRWAIT flow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        rcnt_d  = rcnt_q;

        if (fail) begin
            // Restart fetch after the mispredicted instruction; the add wraps naturally.
            pc_d    = (newPC & ALIGN_MASK) + STEP;
            state_d = ST_RUN;
            cnt_d   = 4'd0;
            if (rcnt_q != '1) begin
                rcnt_d = rcnt_q + CNT_W'(1);
            end
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (JumpReg) begin
                        // First JumpReg edge: park the PC and start counting.
                        cnt_d   = 4'd1;
                        state_d = ST_JRWAIT;
                    end else begin
                        pc_d = nextPC;
                    end
                end
                ST_JRWAIT: begin
                    if (!JumpReg) begin
                        // Upstream dropped the jump: resume as a normal cycle.
                        pc_d    = nextPC;
                        cnt_d   = 4'd0;
                        state_d = ST_RUN;
                    end else if (cnt_q >= JR_WAIT_C) begin
                        pc_d    = nextPC;
                        cnt_d   = 4'd0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Outputs: registered values and decodes of the state register only.
    assign curPC        = pc_q;
    assign redirect_cnt = rcnt_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign jr_busy      = (state_q == ST_JRWAIT);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a default-parameter instance plus a CNT_W=2 instance
// that shares its inputs, so the saturating redirect counter can be seen at its limit.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        fail;
    logic        JumpReg;
    logic [31:0] nextPC;
    logic [31:0] newPC;

    logic [31:0] curPC;
    logic        pc_valid;
    logic        jr_busy;
    logic [15:0] redirect_cnt;

    logic [31:0] s_curPC;
    logic        s_pc_valid;
    logic        s_jr_busy;
    logic [1:0]  s_redirect_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .fail         (fail),
        .JumpReg      (JumpReg),
        .nextPC       (nextPC),
        .newPC        (newPC),
        .curPC        (curPC),
        .pc_valid     (pc_valid),
        .jr_busy      (jr_busy),
        .redirect_cnt (redirect_cnt)
    );

    pc_unit #(.CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .fail         (fail),
        .JumpReg      (JumpReg),
        .nextPC       (nextPC),
        .newPC        (newPC),
        .curPC        (s_curPC),
        .pc_valid     (s_pc_valid),
        .jr_busy      (s_jr_busy),
        .redirect_cnt (s_redirect_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before inputs change or outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full state view of the main instance.
    task automatic check_pc(input string tag, input logic [31:0] pc, input logic busy);
        check({tag, " curPC"}, curPC, pc);
        check({tag, " jr_busy"}, {31'd0, jr_busy}, {31'd0, busy});
        check({tag, " pc_valid"}, {31'd0, pc_valid}, {31'd0, ~busy});
    endtask

    task automatic check_rc(input string tag, input int exp16, input int exp2);
        check({tag, " redirect_cnt"}, {16'd0, redirect_cnt}, 32'(exp16));
        check({tag, " redirect_cnt_sat"}, {30'd0, s_redirect_cnt}, 32'(exp2));
    endtask

    initial begin
        reset   = 1'b0;
        stall   = 1'b0;
        fail    = 1'b0;
        JumpReg = 1'b0;
        nextPC  = 32'h0;
        newPC   = 32'h0;

        // 1: reset
        step();
        reset = 1'b1;
        check_pc("reset", 32'h3000, 1'b0);
        check_rc("reset", 0, 0);

        // 2: sequential fetch, then stall holds
        nextPC = 32'h3004; step(); check_pc("seq1", 32'h3004, 1'b0);
        nextPC = 32'h3008; step(); check_pc("seq2", 32'h3008, 1'b0);
        nextPC = 32'h300C; step(); check_pc("seq3", 32'h300C, 1'b0);
        stall  = 1'b1;
        nextPC = 32'h3010; step(); check_pc("stall1", 32'h300C, 1'b0);
        step();            check_pc("stall2", 32'h300C, 1'b0);
        stall  = 1'b0;

        // 3: jump-register wait, JR_WAIT=2: target lands on the third edge
        JumpReg = 1'b1;
        nextPC  = 32'h3400;
        step(); check_pc("jr_e1", 32'h300C, 1'b1);
        step(); check_pc("jr_e2", 32'h300C, 1'b1);
        step(); check_pc("jr_e3", 32'h3400, 1'b0);
        // A stall in the middle of the wait adds exactly one held edge
        nextPC = 32'h3500;
        step();              check_pc("jrs_e1", 32'h3400, 1'b1);
        stall = 1'b1; step(); check_pc("jrs_stall", 32'h3400, 1'b1);
        stall = 1'b0; step(); check_pc("jrs_e2", 32'h3400, 1'b1);
        step();              check_pc("jrs_e3", 32'h3500, 1'b0);
        JumpReg = 1'b0;
        nextPC  = 32'h3504;
        step(); check_pc("after_jr", 32'h3504, 1'b0);
        // Upstream abort: JumpReg dropped during the wait resumes normal flow
        JumpReg = 1'b1;
        step(); check_pc("abort_e1", 32'h3504, 1'b1);
        JumpReg = 1'b0;
        nextPC  = 32'h3600;
        step(); check_pc("abort_e2", 32'h3600, 1'b0);

        // 4: redirect aligns newPC and skips past it
        fail  = 1'b1;
        newPC = 32'h3011;
        step(); check_pc("redir1", 32'h3014, 1'b0);
        check_rc("redir1", 1, 1);
        fail    = 1'b0;
        JumpReg = 1'b1;
        step(); check_pc("redir_jr", 32'h3014, 1'b1);
        // Redirect beats both stall and the JR wait
        fail  = 1'b1;
        stall = 1'b1;
        newPC = 32'h3102;
        step(); check_pc("redir2", 32'h3104, 1'b0);
        check_rc("redir2", 2, 2);
        fail    = 1'b0;
        stall   = 1'b0;
        JumpReg = 1'b0;
        nextPC  = 32'h3108;
        step(); check_pc("redir_run", 32'h3108, 1'b0);

        // 5: reset during JRWAIT, then a full wait from scratch
        JumpReg = 1'b1;
        nextPC  = 32'h3200;
        step(); check_pc("rst_jr", 32'h3108, 1'b1);
        reset = 1'b0;
        step(); check_pc("rst_mid", 32'h3000, 1'b0);
        check_rc("rst_mid", 0, 0);
        reset = 1'b1;
        step(); check_pc("rst_e1", 32'h3000, 1'b1);
        step(); check_pc("rst_e2", 32'h3000, 1'b1);
        step(); check_pc("rst_e3", 32'h3200, 1'b0);
        JumpReg = 1'b0;

        // 6: counter saturation on the 2-bit instance and address wrap
        fail  = 1'b1;
        newPC = 32'h0000_1000; step(); check_rc("sat1", 1, 1);
        check("sat1 curPC", curPC, 32'h0000_1004);
        newPC = 32'h0000_2003; step(); check_rc("sat2", 2, 2);
        check("sat2 curPC", curPC, 32'h0000_2004);
        newPC = 32'h0000_4000; step(); check_rc("sat3", 3, 3);
        newPC = 32'h0000_5000; step(); check_rc("sat4", 4, 3);
        newPC = 32'hFFFF_FFFC; step(); check_rc("sat5", 5, 3);
        check_pc("wrap", 32'h0000_0000, 1'b0);
        check("wrap sat curPC", s_curPC, 32'h0000_0000);
        newPC = 32'hFFFF_FFFF; step(); check_rc("sat6", 6, 3);
        check("wrap2 curPC", curPC, 32'h0000_0000);
        fail = 1'b0;

        // Misaligned nextPC passes straight through
        nextPC = 32'h0000_3003;
        step(); check_pc("misalign", 32'h0000_3003, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
